ras_stack: RTL and testbench

- Circular return-address LIFO behind the return-address-stack control logic.
- The control logic drives push/pop from the execute stage. The stack supplies the top-of-stack target that fetch/decode uses for return prediction.
- Depth-bounded. On overflow the newest entry overwrites the oldest; no stall is ever raised.
- Flush support for pipeline redirects. Optional checkpoint/restore for speculative repair.

---
 rtl/ras_types.sv | 13 +
 rtl/ras_stack.sv | 95 +++++++++
 tb/tb_ras_stack.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_types.sv
// Shared types for the return-address stack.
package ras_types;
    localparam int RAS_DEPTH = 8;

    typedef logic [$clog2(RAS_DEPTH)-1:0]   ras_ptr_t;
    typedef logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt_t;

    typedef struct packed {
        ras_ptr_t    tos;
        ras_cnt_t    count;
        logic [31:0] top;
    } ras_ckpt_t;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO; newest push overwrites oldest when full.
// Define RAS_CHECKPOINT_EN to add a single checkpoint/restore slot for speculative repair.
module ras_stack
    import ras_types::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
`ifdef RAS_CHECKPOINT_EN
    input  logic                       ckpt_save,
    input  logic                       ckpt_restore,
`endif
    output logic [WIDTH-1:0]           peek,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;

`ifdef RAS_CHECKPOINT_EN
    logic [PTR_W-1:0] ckpt_tos;
    logic [CNT_W-1:0] ckpt_count;
    logic [WIDTH-1:0] ckpt_top;
`endif

    assign tos_inc = tos + 1'b1;
    assign tos_dec = tos - 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            tos       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef RAS_CHECKPOINT_EN
            ckpt_tos   <= '0;
            ckpt_count <= '0;
            ckpt_top   <= '0;
`endif
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef RAS_CHECKPOINT_EN
            // Snapshot always sees pre-update state; a concurrent restore keeps the old snapshot.
            if (ckpt_save && !ckpt_restore) begin
                ckpt_tos   <= tos;
                ckpt_count <= count;
                ckpt_top   <= mem[tos];
            end
            if (ckpt_restore) begin
                tos           <= ckpt_tos;
                count         <= ckpt_count;
                mem[ckpt_tos] <= ckpt_top;
            end else
`endif
            if (flush) begin
                count <= '0;
            end else if (push && pop && count != '0) begin
                mem[tos] <= datain;
            end else if (push) begin
                tos          <= tos_inc;
                mem[tos_inc] <= datain;
                if (count == CNT_MAX) overflow <= 1'b1;
                else                  count    <= count + 1'b1;
            end else if (pop) begin
                if (count == '0) begin
                    underflow <= 1'b1;
                end else begin
                    tos   <= tos_dec;
                    count <= count - 1'b1;
                end
            end
        end
    end

    assign peek  = (count != '0) ? mem[tos] : '0;
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack against a queue-based LIFO model.
module tb_ras_stack;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] datain = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             flush = 1'b0;
    logic             ckpt_save = 1'b0;
    logic             ckpt_restore = 1'b0;
    logic [WIDTH-1:0] peek;
    logic             empty;
    logic             full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    // Model: q holds valid entries bottom..top.
    logic [WIDTH-1:0] q[$];
    logic             exp_ovf;
    logic             exp_unf;

    ras_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .datain(datain),
        .push(push),
        .pop(pop),
        .flush(flush),
`ifdef RAS_CHECKPOINT_EN
        .ckpt_save(ckpt_save),
        .ckpt_restore(ckpt_restore),
`endif
        .peek(peek),
        .empty(empty),
        .full(full),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_peek();
        return (q.size() > 0) ? q[q.size()-1] : '0;
    endfunction

    function automatic logic [3:0] exp_count();
        return 4'(q.size());
    endfunction

    task automatic model_step(input logic p, input logic o, input logic f, input logic [WIDTH-1:0] d);
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else if (f) begin
            q.delete();
        end else if (p && o && q.size() > 0) begin
            q[q.size()-1] = d;
        end else if (p) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                exp_ovf = 1'b1;
            end
            q.push_back(d);
        end else if (o) begin
            if (q.size() == 0) exp_unf = 1'b1;
            else void'(q.pop_back());
        end
    endtask

    task automatic cyc(input logic p, input logic o, input logic f, input logic [WIDTH-1:0] d);
        push = p; pop = o; flush = f; datain = d;
        @(posedge clk);
        model_step(p, o, f, d);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'h1234);
        cyc(1'b1, 1'b0, 1'b0, 32'h1234);
        checks++;
        if (peek !== 32'h0 || empty !== 1'b1 || count !== 4'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: peek=%h empty=%b count=%0d full=%b, required peek=0 empty=1 count=0 full=0", peek, empty, count, full);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: ovf=%b unf=%b, required 0 0", overflow, underflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_lifo();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h200);
        cyc(1'b1, 1'b0, 1'b0, 32'h300);
        checks++;
        if (peek !== 32'h300 || count !== 4'd3) begin
            errors++;
            $display("FAIL lifo_push: peek=%h count=%0d, required 300 3", peek, count);
        end
        cyc(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (peek !== 32'h200 || count !== 4'd2) begin
            errors++;
            $display("FAIL lifo_pop: peek=%h count=%0d, required 200 2", peek, count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'(i * 16));
            checks++;
            if (overflow !== (i == 9)) begin
                errors++;
                $display("FAIL ovf_pulse push%0d: ovf=%b, required %b", i, overflow, (i == 9));
            end
        end
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_count: count=%0d full=%b, required 8 1", count, full);
        end
        for (int i = 9; i >= 2; i--) begin
            checks++;
            if (peek !== 32'(i * 16)) begin
                errors++;
                $display("FAIL ovf_drain%0d: peek=%h, required %h", i, peek, 32'(i * 16));
            end
            cyc(1'b0, 1'b1, 1'b0, '0);
        end
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || peek !== 32'h0) begin
            errors++;
            $display("FAIL ovf_empty: empty=%b count=%0d peek=%h, required 1 0 0", empty, count, peek);
        end
    endtask

    task automatic test_underflow_simul();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL unf_pulse: unf=%b count=%0d empty=%b, required 1 0 1", underflow, count, empty);
        end
        cyc(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_oneshot: unf=%b, required 0", underflow);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h30);
        checks++;
        if (peek !== 32'h30 || count !== 4'd1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_empty: peek=%h count=%0d unf=%b, required 30 1 0", peek, count, underflow);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h40);
        cyc(1'b1, 1'b1, 1'b0, 32'h44);
        checks++;
        if (peek !== 32'h44 || count !== 4'd2 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_replace: peek=%h count=%0d ovf=%b unf=%b, required 44 2 0 0", peek, count, overflow, underflow);
        end
        cyc(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (peek !== 32'h30) begin
            errors++;
            $display("FAIL pushpop_below: peek=%h, required 30", peek);
        end
    endtask

    task automatic test_flush();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h2);
        cyc(1'b1, 1'b0, 1'b0, 32'h3);
        cyc(1'b1, 1'b0, 1'b1, 32'h4);
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || peek !== 32'h0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush: count=%0d empty=%b peek=%h ovf=%b, required 0 1 0 0", count, empty, peek, overflow);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h5);
        checks++;
        if (peek !== 32'h5 || count !== 4'd1) begin
            errors++;
            $display("FAIL flush_then_push: peek=%h count=%0d, required 5 1", peek, count);
        end
    endtask

    task automatic test_random();
        logic p, o, f;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 40);
            f = ($urandom_range(0, 99) < 4);
            rst_n = ($urandom_range(0, 99) >= 2);
            cyc(p, o, f, $urandom);
            checks++;
            if (peek !== exp_peek()) begin
                errors++;
                $display("FAIL rand_peek cyc%0d: peek=%h, required %h", n, peek, exp_peek());
            end
            checks++;
            if (count !== exp_count() || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
                errors++;
                $display("FAIL rand_count cyc%0d: count=%0d empty=%b full=%b, required count %0d", n, count, empty, full, exp_count());
            end
            checks++;
            if (overflow !== exp_ovf || underflow !== exp_unf) begin
                errors++;
                $display("FAIL rand_pulse cyc%0d: ovf=%b unf=%b, required %b %b", n, overflow, underflow, exp_ovf, exp_unf);
            end
        end
        rst_n = 1'b1;
    endtask

`ifdef RAS_CHECKPOINT_EN
    task automatic test_checkpoint();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'hA0);
        ckpt_save = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, '0);
        ckpt_save = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'hB0);
        checks++;
        if (peek !== 32'hB0 || count !== 4'd1) begin
            errors++;
            $display("FAIL ckpt_wrongpath: peek=%h count=%0d, required B0 1", peek, count);
        end
        ckpt_restore = 1'b1;
        ckpt_save = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 32'hC0);
        ckpt_save = 1'b0;
        ckpt_restore = 1'b0;
        checks++;
        if (peek !== 32'hA0 || count !== 4'd1) begin
            errors++;
            $display("FAIL ckpt_restore: peek=%h count=%0d, required A0 1", peek, count);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'hD0);
        cyc(1'b1, 1'b0, 1'b0, 32'hE0);
        ckpt_restore = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0);
        ckpt_restore = 1'b0;
        checks++;
        if (peek !== 32'hA0 || count !== 4'd1) begin
            errors++;
            $display("FAIL ckpt_kept: peek=%h count=%0d, required A0 1", peek, count);
        end
        q.delete();
        q.push_back(32'hA0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_lifo();
        test_overflow();
        test_underflow_simul();
        test_flush();
`ifdef RAS_CHECKPOINT_EN
        test_checkpoint();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
